// File: rtl/inst_loader_pkg.sv
// ============================================================================
// inst_loader_pkg
// Shared types and constants for the boot-time instruction loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inst_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEPTH_WORDS_DEFAULT = 256;
  localparam int BYTES_PER_WORD      = 4;

endpackage

`default_nettype wire

// File: rtl/inst_loader_word_assembler.sv
// ============================================================================
// word_assembler
// Packs accepted bytes little-endian into a 32-bit word; flags the 4th byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module word_assembler
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  localparam logic [1:0] c_LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_lanes;

  // The top lane is never stored: the completed word is presented combinationally
  // alongside the 4th byte so the caller can latch it on the same edge.
  assign o_word      = {i_byte, r_lanes};
  assign o_word_full = i_accept && (r_byte_cnt == c_LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_byte_cnt <= 2'd0;
      r_lanes    <= 24'd0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      case (r_byte_cnt)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: r_lanes        <= r_lanes;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// inst_loader
// Loads a byte stream into instruction memory as 32-bit words, holding the CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold,
  output logic [31:0] checksum
);

  localparam int CW = $clog2(DEPTH_WORDS + 1);

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_word_cnt;
  logic            r_byte_ready;
  logic            r_we;
  logic [31:0]     r_waddr;
  logic [31:0]     r_wdata;
  logic            r_busy;
  logic            r_done;
  logic            r_cpu_hold;
  logic [31:0]     r_checksum;

  logic [CW-1:0]   w_count;
  logic            w_start_ok;
  logic            w_accept;
  logic [31:0]     w_word;
  logic            w_word_full;
  logic            w_last_word;

  // Clamping the count bounds every write address to the memory depth.
  always_comb begin
    w_count = CW'(num_words);
    if (32'(num_words) > 32'(DEPTH_WORDS)) begin
      w_count = CW'(DEPTH_WORDS);
    end
  end

  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept    = byte_valid && r_byte_ready;
  assign w_last_word = ((r_word_cnt + CW'(1)) == r_count);

  word_assembler u_word_assembler (
    .clk         (clk),
    .rst         (reset),
    .i_clear     (w_start_ok),
    .i_accept    (w_accept),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_word_cnt   <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= 32'd0;
      r_wdata      <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_checksum   <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_count    <= w_count;
            r_word_cnt <= '0;
            r_checksum <= 32'd0;
            if (w_count == '0) begin
              r_state      <= ST_DONE;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_cpu_hold   <= 1'b0;
            end else begin
              r_state      <= ST_RECV;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
              r_cpu_hold   <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (w_word_full) begin
            r_state      <= ST_WRITE;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b1;
            r_waddr      <= 32'({r_word_cnt, 2'b00});
            r_wdata      <= w_word;
          end
        end

        ST_WRITE: begin
          r_we       <= 1'b0;
          r_checksum <= r_checksum ^ r_wdata;
          r_word_cnt <= r_word_cnt + CW'(1);
          if (w_last_word) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state      <= ST_RECV;
            r_byte_ready <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cpu_hold   = r_cpu_hold;
  assign checksum   = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// tb_inst_loader
// Self-checking bench for inst_loader with a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim[$];
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_cs;
  int          we_ready_overlap = 0;
  int          late_ready = 0;

  inst_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      mon_addr.push_back(waddr);
      mon_data.push_back(wdata);
      if (byte_ready !== 1'b0) we_ready_overlap++;
    end
  end

  // Word k is bytes 4k..4k+3 little-endian at address 4k; count clamped to 256.
  function automatic void model_load(input int nw);
    int n;
    n = (nw > 256) ? 256 : nw;
    exp_addr.delete();
    exp_data.delete();
    exp_cs = 32'd0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      w = 32'(stim[4*k]) + (32'(stim[4*k+1]) << 8) + (32'(stim[4*k+2]) << 16)
          + (32'(stim[4*k+3]) << 24);
      exp_addr.push_back(32'(k * 4));
      exp_data.push_back(w);
      exp_cs = exp_cs ^ w;
    end
  endfunction

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    we_ready_overlap = 0;
    late_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [8:0] nw);
    start = 1'b1;
    num_words = nw;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // gap: 0 continuous, 1 alternate cycles, 2 random
  task automatic stream(input int gap, input int start_cyc, input logic [8:0] start_nw,
                        input int maxcyc, output int consumed);
    int idx = 0;
    logic acc;
    for (int c = 0; c < maxcyc && idx < stim.size(); c++) begin
      byte_valid = (gap == 0) ? 1'b1 : (gap == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      byte_data  = stim[idx];
      start      = (c == start_cyc);
      num_words  = start_nw;
      @(negedge clk);
      acc = byte_valid && byte_ready;
      if (done === 1'b1 && byte_ready !== 1'b0) late_ready++;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    consumed   = idx;
  endtask

  task automatic wait_done(input int maxcyc, input string nm);
    int c = 0;
    while (done !== 1'b1 && c < maxcyc) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b required 1 within %0d cycles", nm, done, maxcyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({byte_ready, we, busy, done, cpu_hold} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl: {rdy,we,busy,done,hold}=%b required 00001",
               {byte_ready, we, busy, done, cpu_hold});
    end
    checks++;
    if (waddr !== 32'd0 || wdata !== 32'd0 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: waddr=%h wdata=%h cs=%h required 0", waddr, wdata, checksum);
    end
  endtask

  task automatic test_basic(input int gap, input string nm);
    int used;
    stim = '{8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h82, 8'h30, 8'h40};
    model_load(2);
    clear_mon();
    pulse_start(9'd2);
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_latency: busy=%b rdy=%b done=%b required 1 1 0", nm, busy, byte_ready, done);
    end
    stream(gap, -1, 9'd0, 100, used);
    wait_done(20, nm);
    checks++;
    if (mon_addr.size() !== 2) begin
      errors++;
      $display("FAIL %s_we_count: got %0d required 2", nm, mon_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL %s_write%0d: addr=%h data=%h required addr=%h data=%h",
                   nm, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if (mon_data[0] !== 32'h00110233 || mon_data[1] !== 32'h403082B3) begin
        errors++;
        $display("FAIL %s_words: %h %h required 00110233 403082B3", nm, mon_data[0], mon_data[1]);
      end
    end
    checks++;
    if (checksum !== 32'h40218080 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: cs=%h hold=%b busy=%b required 40218080 0 0", nm, checksum, cpu_hold, busy);
    end
    checks++;
    if (we_ready_overlap !== 0) begin
      errors++;
      $display("FAIL %s_ready_in_write: %0d cycles required 0", nm, we_ready_overlap);
    end
  endtask

  task automatic test_zero_count();
    clear_mon();
    pulse_start(9'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL zero_count: done=%b busy=%b hold=%b cs=%h required 1 0 0 0", done, busy, cpu_hold, checksum);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (6) @(posedge clk);
    #1 byte_valid = 1'b0;
    checks++;
    if (mon_addr.size() !== 0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_count_idle: we=%0d rdy=%b required 0 0", mon_addr.size(), byte_ready);
    end
  endtask

  task automatic test_mid_reset();
    int used;
    stim = '{8'hAA, 8'hBB};
    clear_mon();
    pulse_start(9'd1);
    stream(0, -1, 9'd0, 20, used);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({byte_ready, we, busy, done, cpu_hold} !== 5'b00001 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL midreset_state: {rdy,we,busy,done,hold}=%b cs=%h required 00001 0",
               {byte_ready, we, busy, done, cpu_hold}, checksum);
    end
    reset = 1'b0;
    stim = '{8'h13, 8'h00, 8'h00, 8'h00};
    pulse_start(9'd1);
    stream(0, -1, 9'd0, 20, used);
    wait_done(20, "midreset");
    checks++;
    if (mon_addr.size() !== 1 || mon_addr[0] !== 32'd0 || mon_data[0] !== 32'h00000013) begin
      errors++;
      $display("FAIL midreset_reload: n=%0d addr=%h data=%h required 1 0 00000013",
               mon_addr.size(), mon_addr[0], mon_data[0]);
    end
  endtask

  task automatic test_start_handling();
    int used;
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    model_load(2);
    clear_mon();
    pulse_start(9'd2);
    stream(0, 3, 9'd7, 100, used);
    wait_done(20, "start_in_recv");
    checks++;
    if (mon_addr.size() !== 2 || checksum !== exp_cs) begin
      errors++;
      $display("FAIL start_in_recv: n=%0d cs=%h required 2 %h", mon_addr.size(), checksum, exp_cs);
    end
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
    model_load(1);
    clear_mon();
    pulse_start(9'd1);
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || checksum !== 32'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done: done=%b hold=%b cs=%h busy=%b required 0 1 0 1",
               done, cpu_hold, checksum, busy);
    end
    stream(0, -1, 9'd0, 20, used);
    wait_done(20, "start_in_done");
    checks++;
    if (mon_addr.size() !== 1 || mon_addr[0] !== 32'd0 || mon_data[0] !== exp_data[0]) begin
      errors++;
      $display("FAIL start_in_done_reload: n=%0d addr=%h data=%h required 1 0 %h",
               mon_addr.size(), mon_addr[0], mon_data[0], exp_data[0]);
    end
  endtask

  task automatic test_random();
    int used;
    for (int it = 0; it < 5; it++) begin
      int nw = $urandom_range(1, 7);
      int gp = $urandom_range(0, 2);
      stim.delete();
      for (int i = 0; i < 4*nw; i++) stim.push_back(8'($urandom));
      model_load(nw);
      clear_mon();
      pulse_start(9'(nw));
      stream(gp, -1, 9'd0, 400, used);
      wait_done(20, "random");
      checks++;
      if (mon_addr.size() !== exp_addr.size() || checksum !== exp_cs) begin
        errors++;
        $display("FAIL random%0d: n=%0d cs=%h required n=%0d cs=%h",
                 it, mon_addr.size(), checksum, exp_addr.size(), exp_cs);
      end else begin
        for (int i = 0; i < nw; i++) begin
          checks++;
          if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL random%0d_w%0d: addr=%h data=%h required %h %h",
                     it, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
    end
  endtask

  task automatic test_clamp();
    int used;
    int bad = 0;
    stim.delete();
    for (int i = 0; i < 1200; i++) stim.push_back(8'($urandom));
    model_load(300);
    clear_mon();
    pulse_start(9'd300);
    stream(0, -1, 9'd0, 1600, used);
    checks++;
    if (done !== 1'b1 || used !== 1024 || late_ready !== 0) begin
      errors++;
      $display("FAIL clamp_stop: done=%b consumed=%0d late_rdy=%0d required 1 1024 0", done, used, late_ready);
    end
    checks++;
    if (mon_addr.size() !== 256 || mon_addr[mon_addr.size()-1] !== 32'h3FC) begin
      errors++;
      $display("FAIL clamp_count: n=%0d last=%h required 256 000003fc",
               mon_addr.size(), mon_addr[mon_addr.size()-1]);
    end else begin
      for (int i = 0; i < 256; i++)
        if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) bad++;
      checks++;
      if (bad !== 0 || checksum !== exp_cs) begin
        errors++;
        $display("FAIL clamp_data: bad_words=%0d cs=%h required 0 %h", bad, checksum, exp_cs);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_words = 9'd0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    test_reset();
    test_basic(0, "basic");
    test_zero_count();
    test_basic(1, "gapped");
    test_mid_reset();
    test_start_handling();
    test_random();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
